// File: rtl/tlul_err_resp_q_if.sv
// TL-UL 32-bit host<->device channel bundle for the queued error responder.
// master = host side, slave = device side.
interface tlul_err_resp_q_if;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic [7:0]  a_user;
  logic        a_ready;

  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic [7:0]  d_user;
  logic        d_error;
  logic        d_ready;

  modport master (
    output a_valid, a_opcode, a_param,
    output a_size, a_source, a_address,
    output a_mask, a_data, a_user,
    output d_ready,
    input  a_ready,
    input  d_valid, d_opcode, d_param,
    input  d_size, d_source, d_sink,
    input  d_data, d_user, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_param,
    input  a_size, a_source, a_address,
    input  a_mask, a_data, a_user,
    input  d_ready,
    output a_ready,
    output d_valid, d_opcode, d_param,
    output d_size, d_source, d_sink,
    output d_data, d_user, d_error
  );
endinterface

// File: rtl/tlul_err_resp_q.sv
// Queued TL-UL error responder for unmapped space, Depth outstanding requests.
// Optional error logging enabled by defining TLUL_ERR_RESP_LOG_EN.
module tlul_err_resp_q #(
  parameter int unsigned Depth   = 2,
  parameter logic [31:0] ErrData = 32'hFFFF_FFFF,
  parameter int unsigned CntW    = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  tlul_err_resp_q_if.slave tl_h,
  input  logic            err_clr_i,
  output logic [CntW-1:0] err_cnt_o,
  output logic [31:0]     err_addr_o,
  output logic            err_seen_o
);

  localparam int unsigned OccW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [2:0] OpGet     = 3'd4;
  localparam logic [2:0] OpAck     = 3'd0;
  localparam logic [2:0] OpAckData = 3'd1;

  logic [OccW-1:0] occ_q, occ_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;

  logic [7:0] src_mem  [Depth];
  logic [1:0] size_mem [Depth];
  logic [2:0] op_mem   [Depth];

  logic full, empty, push, pop;

  assign full  = (occ_q == OccW'(Depth));
  assign empty = (occ_q == '0);
  assign push  = tl_h.a_valid & ~full;
  assign pop   = tl_h.d_ready & ~empty;

  function automatic logic [PtrW-1:0] ptr_inc(
    input logic [PtrW-1:0] p
  );
    if (p == PtrW'(Depth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  always_comb begin
    occ_d  = occ_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      occ_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      occ_q  <= occ_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is deliberately not reset; d_* are gated by empty instead.
  always_ff @(posedge clk_i) begin
    if (push) begin
      src_mem[wptr_q]  <= tl_h.a_source;
      size_mem[wptr_q] <= tl_h.a_size;
      op_mem[wptr_q]   <= tl_h.a_opcode;
    end
  end

  assign tl_h.a_ready  = ~full;
  assign tl_h.d_valid  = ~empty;
  assign tl_h.d_opcode = (!empty && op_mem[rptr_q] != OpGet)
                         ? OpAck : OpAckData;
  assign tl_h.d_source = empty ? '0 : src_mem[rptr_q];
  assign tl_h.d_size   = empty ? '0 : size_mem[rptr_q];
  assign tl_h.d_data   = ErrData;
  assign tl_h.d_error  = 1'b1;
  assign tl_h.d_param  = '0;
  assign tl_h.d_sink   = 1'b0;
  assign tl_h.d_user   = '0;

`ifdef TLUL_ERR_RESP_LOG_EN
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic            seen_q, seen_d;

  // An accept in the same cycle as a clear wins and counts as one.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    seen_d = seen_q;
    if (err_clr_i) begin
      cnt_d  = '0;
      seen_d = 1'b0;
    end
    if (push) begin
      addr_d = tl_h.a_address;
      seen_d = 1'b1;
      if (err_clr_i)   cnt_d = CntW'(1);
      else if (&cnt_q) cnt_d = cnt_q;
      else             cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      addr_q <= '0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      seen_q <= seen_d;
    end
  end

  assign err_cnt_o  = cnt_q;
  assign err_addr_o = addr_q;
  assign err_seen_o = seen_q;

  logic unused_sig;
  assign unused_sig = ^{tl_h.a_param, tl_h.a_mask,
                        tl_h.a_data, tl_h.a_user};
`else
  assign err_cnt_o  = '0;
  assign err_addr_o = '0;
  assign err_seen_o = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{tl_h.a_param, tl_h.a_mask,
                        tl_h.a_data, tl_h.a_user,
                        tl_h.a_address, err_clr_i};
`endif

endmodule

// File: tb/tb_tlul_err_resp_q.sv
// Scoreboard bench for tlul_err_resp_q (Depth=2, CntW=4).
// Logging checks follow TLUL_ERR_RESP_LOG_EN.
module tb_tlul_err_resp_q;

  localparam logic [2:0] PUT = 3'd0;
  localparam logic [2:0] GET = 3'd4;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] err_cnt;
  logic [31:0] err_addr;
  logic       err_seen;

  tlul_err_resp_q_if tl ();

  tlul_err_resp_q #(
    .Depth  (2),
    .ErrData(32'hFFFF_FFFF),
    .CntW   (4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .tl_h      (tl.slave),
    .err_clr_i (err_clr),
    .err_cnt_o (err_cnt),
    .err_addr_o(err_addr),
    .err_seen_o(err_seen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] src;
    logic [1:0] size;
    logic [2:0] dop;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

`ifdef TLUL_ERR_RESP_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      if (tl.d_valid && tl.d_ready) begin
        chk("d_has_exp", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("d_source", 64'(tl.d_source), 64'(e.src));
          chk("d_size",   64'(tl.d_size),   64'(e.size));
          chk("d_opcode", 64'(tl.d_opcode), 64'(e.dop));
          chk("d_data",   64'(tl.d_data),   64'hFFFF_FFFF);
          chk("d_error",  64'(tl.d_error),  64'd1);
          chk("d_misc", 64'({tl.d_param, tl.d_sink, tl.d_user}), 64'd0);
        end
      end
      if (tl.a_valid && tl.a_ready) begin
        exp_t e;
        e.src  = tl.a_source;
        e.size = tl.a_size;
        e.dop  = (tl.a_opcode == GET) ? 3'd1 : 3'd0;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a request until accepted; leaves a_valid high for back-to-back use.
  task automatic send(input logic [2:0] op, input logic [7:0] src,
                      input logic [1:0] size, input logic [31:0] addr,
                      output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    tl.a_valid   = 1'b1;
    tl.a_opcode  = op;
    tl.a_source  = src;
    tl.a_size    = size;
    tl.a_address = addr;
    tl.a_data    = $urandom;
    tl.a_mask    = 4'hF;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tl.a_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
      tick();
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !tl.d_valid) break;
      tick();
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_dvalid", 64'(tl.d_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout got 0 expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    tl.a_valid = 1'b0; tl.a_opcode = '0; tl.a_param = '0;
    tl.a_size = '0; tl.a_source = '0; tl.a_address = '0;
    tl.a_mask = '0; tl.a_data = '0; tl.a_user = '0;
    tl.d_ready = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;

    @(negedge clk);
    chk("rst_a_ready",  64'(tl.a_ready),  64'd1);
    chk("rst_d_valid",  64'(tl.d_valid),  64'd0);
    chk("rst_d_source", 64'(tl.d_source), 64'd0);
    chk("rst_d_size",   64'(tl.d_size),   64'd0);
    chk("rst_d_opcode", 64'(tl.d_opcode), 64'd1);
    chk("rst_log", 64'({err_cnt, err_addr, err_seen}), 64'd0);
    tick();

    // single Get, one-cycle latency
    tl.d_ready = 1'b1;
    tl.a_valid = 1'b1; tl.a_opcode = GET;
    tl.a_source = 8'd3; tl.a_size = 2'd2;
    @(negedge clk);
    chk("t1_no_comb", 64'(tl.d_valid), 64'd0);
    tick();
    tl.a_valid = 1'b0;
    @(negedge clk);
    chk("t1_dvalid", 64'(tl.d_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("t1_dvalid_off", 64'(tl.d_valid), 64'd0);
    tick();

    // 8 back-to-back puts at full throughput
    for (int i = 0; i < 8; i++) begin
      send(PUT, 8'(i), 2'd2, 32'h0, w);
      chk("t2_no_stall", 64'(w), 64'd0);
      @(negedge clk);
      chk("t2_dvalid", 64'(tl.d_valid), 64'd1);
    end
    tl.a_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t2_done", 64'(tl.d_valid), 64'd0);
    chk("t2_sb", 64'(sb.size()), 64'd0);
    tick();

    // backpressure: third Get blocked until a pop frees a slot
    tl.d_ready = 1'b0;
    send(GET, 8'd10, 2'd0, 32'h0, w);
    send(GET, 8'd11, 2'd1, 32'h0, w);
    tl.a_source = 8'd12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_full", 64'(tl.a_ready), 64'd0);
      chk("t3_hold_src", 64'(tl.d_source), 64'd10);
      chk("t3_hold_v", 64'(tl.d_valid), 64'd1);
      tick();
    end
    tl.d_ready = 1'b1;
    @(negedge clk);
    chk("t3_no_bypass", 64'(tl.a_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("t3_slot_free", 64'(tl.a_ready), 64'd1);
    tick();
    tl.a_valid = 1'b0;
    drain();
    tick();

    // reset with two queued entries
    tl.d_ready = 1'b0;
    send(GET, 8'd20, 2'd0, 32'h0, w);
    send(GET, 8'd21, 2'd0, 32'h0, w);
    tl.a_valid = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t4_dvalid", 64'(tl.d_valid), 64'd0);
    chk("t4_a_ready", 64'(tl.a_ready), 64'd1);
    tick();
    tl.d_ready = 1'b1;
    send(GET, 8'd5, 2'd1, 32'h0, w);
    tl.a_valid = 1'b0;
    drain();

    // logging: 17 errors saturate a 4-bit counter
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 17; i++)
      send(PUT, 8'(i), 2'd2, 32'h4000_0000 + 32'(4 * i), w);
    tl.a_valid = 1'b0;
    @(negedge clk);
    chk("t5_cnt",  64'(err_cnt),  LOG ? 64'd15 : 64'd0);
    chk("t5_addr", 64'(err_addr), LOG ? 64'h4000_0040 : 64'd0);
    chk("t5_seen", 64'(err_seen), LOG ? 64'd1 : 64'd0);
    tick();
    drain();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr_cnt",  64'(err_cnt),  64'd0);
    chk("t5_clr_seen", 64'(err_seen), 64'd0);
    tick();
    err_clr = 1'b1;
    send(PUT, 8'd1, 2'd2, 32'h4000_1000, w);
    err_clr = 1'b0;
    tl.a_valid = 1'b0;
    @(negedge clk);
    chk("t5_clr_acc_cnt",  64'(err_cnt),  LOG ? 64'd1 : 64'd0);
    chk("t5_clr_acc_seen", 64'(err_seen), LOG ? 64'd1 : 64'd0);
    chk("t5_clr_acc_addr", 64'(err_addr), LOG ? 64'h4000_1000 : 64'd0);
    tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
